// File: rtl/pool_lock_pkg.sv
// Shared types and helpers for the pool lock sequencer and the pool itself.
package pool_lock_pkg;

  // Per-channel sequencer state.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } lock_state_e;

  // Width of the saturating wait counter; starve limits must fit in it.
  localparam int WAIT_CNT_W = 8;

  // Default field widths of the channel context record.
  localparam int CTX_ID_W   = 6;
  localparam int CTX_HOLD_W = 4;
  localparam int CTX_RID_W  = 1;

  // Resource-ID width that stays at least one bit for a single-entry pool.
  function automatic int rid_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Channel context in the default configuration, shared with the pool trace logic.
  typedef struct packed {
    logic [CTX_ID_W-1:0]   issue_id;
    logic [CTX_HOLD_W-1:0] hold_rem;
    logic [CTX_RID_W-1:0]  res_id;
    logic [WAIT_CNT_W-1:0] wait_cnt;
  } chan_ctx_t;

endpackage

// File: rtl/pool_lock_channel.sv
// Single-port lock client: request, own the granted resource for hold+1 cycles, release.
module pool_lock_channel
  import pool_lock_pkg::*;
#(
  parameter int ID_WIDTH     = 6,
  parameter int HOLD_WIDTH   = 4,
  parameter int RID_W        = 1,
  parameter int STARVE_LIMIT = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_op_valid,
  output logic                  o_op_ready,
  input  logic [ID_WIDTH-1:0]   i_op_issue_id,
  input  logic [HOLD_WIDTH-1:0] i_op_hold,
  input  logic                  i_flush,
  output logic                  o_pool_req,
  output logic [ID_WIDTH-1:0]   o_pool_issue_id,
  output logic                  o_pool_release,
  input  logic                  i_pool_grant,
  input  logic [RID_W-1:0]      i_pool_alloc_id,
  output logic                  o_use_valid,
  output logic [RID_W-1:0]      o_use_res_id,
  output logic                  o_done,
  output logic                  o_starve
);

  localparam logic [WAIT_CNT_W-1:0] STARVE_THR = WAIT_CNT_W'(STARVE_LIMIT);
  localparam logic [WAIT_CNT_W-1:0] WAIT_MAX   = '1;
  localparam logic [HOLD_WIDTH-1:0] HOLD_ONE   = HOLD_WIDTH'(1);

  lock_state_e           r_state;
  lock_state_e           w_state_next;
  logic [ID_WIDTH-1:0]   r_issue_id;
  logic [HOLD_WIDTH-1:0] r_hold;
  logic [HOLD_WIDTH-1:0] r_hold_rem;
  logic [RID_W-1:0]      r_res_id;
  logic [WAIT_CNT_W-1:0] r_wait_cnt;
  logic                  w_accept;
  logic                  w_grant_ok;

  assign w_accept   = (r_state == IDLE) && i_op_valid && !i_flush;
  assign w_grant_ok = (r_state == WAIT) && i_pool_grant && !i_flush;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state decision; flush returns any busy channel to IDLE.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: if (w_accept) w_state_next = WAIT;
      WAIT: begin
        if (i_flush)           w_state_next = IDLE;
        else if (i_pool_grant) w_state_next = (r_hold == '0) ? IDLE : HOLD;
      end
      HOLD: begin
        if (i_flush || (r_hold_rem == HOLD_ONE)) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Pool handshake and client outputs; the grant cycle forwards alloc_id combinationally.
  always_comb begin
    o_op_ready      = 1'b0;
    o_pool_req      = 1'b0;
    o_pool_issue_id = '0;
    o_pool_release  = 1'b0;
    o_use_valid     = 1'b0;
    o_use_res_id    = '0;
    o_done          = 1'b0;
    o_starve        = 1'b0;
    case (r_state)
      IDLE: o_op_ready = !i_flush;
      WAIT: begin
        o_pool_req      = 1'b1;
        o_pool_issue_id = r_issue_id;
        o_starve        = (r_wait_cnt >= STARVE_THR);
        if (i_flush) begin
          // Releasing here drops a grant that coincides with the flush.
          o_pool_release = 1'b1;
        end else if (i_pool_grant) begin
          o_use_valid  = 1'b1;
          o_use_res_id = i_pool_alloc_id;
          if (r_hold == '0) begin
            o_pool_release = 1'b1;
            o_done         = 1'b1;
          end
        end
      end
      HOLD: begin
        o_pool_req      = 1'b1;
        o_pool_issue_id = r_issue_id;
        if (i_flush) begin
          o_pool_release = 1'b1;
        end else begin
          o_use_valid  = 1'b1;
          o_use_res_id = r_res_id;
          if (r_hold_rem == HOLD_ONE) begin
            o_pool_release = 1'b1;
            o_done         = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // Operation context: latch on accept, capture resource on grant, count wait and hold cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_issue_id <= '0;
      r_hold     <= '0;
      r_hold_rem <= '0;
      r_res_id   <= '0;
      r_wait_cnt <= '0;
    end else begin
      if (w_accept) begin
        r_issue_id <= i_op_issue_id;
        r_hold     <= i_op_hold;
        r_wait_cnt <= '0;
      end
      if (w_grant_ok) begin
        r_res_id   <= i_pool_alloc_id;
        r_hold_rem <= r_hold;
      end else if ((r_state == WAIT) && !i_pool_grant && !i_flush && (r_wait_cnt != WAIT_MAX)) begin
        r_wait_cnt <= r_wait_cnt + 1'b1;
      end
      if ((r_state == HOLD) && !i_flush) begin
        r_hold_rem <= r_hold_rem - 1'b1;
      end
    end
  end

  // The pool must keep granting for as long as this channel owns the resource.
  a_grant_held: assert property (@(posedge clk) disable iff (!rst_n)
    ((r_state == HOLD) && !i_flush) |-> i_pool_grant);

endmodule

// File: rtl/pool_lock_sequencer.sv
// Array of independent lock channels, one per pool port, sharing only the flush input.
module pool_lock_sequencer
  import pool_lock_pkg::*;
#(
  parameter int NUM_PORTS     = 4,
  parameter int NUM_RESOURCES = 2,
  parameter int ID_WIDTH      = 6,
  parameter int HOLD_WIDTH    = 4,
  parameter int STARVE_LIMIT  = 15,
  localparam int RID_W        = rid_width(NUM_RESOURCES)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_PORTS-1:0]             i_op_valid,
  output logic [NUM_PORTS-1:0]             o_op_ready,
  input  logic [NUM_PORTS*ID_WIDTH-1:0]    i_op_issue_id,
  input  logic [NUM_PORTS*HOLD_WIDTH-1:0]  i_op_hold,
  input  logic                             i_flush,
  output logic [NUM_PORTS-1:0]             o_pool_req,
  output logic [NUM_PORTS*ID_WIDTH-1:0]    o_pool_issue_id,
  output logic [NUM_PORTS-1:0]             o_pool_release,
  input  logic [NUM_PORTS-1:0]             i_pool_grant,
  input  logic [NUM_PORTS*RID_W-1:0]       i_pool_alloc_id,
  output logic [NUM_PORTS-1:0]             o_use_valid,
  output logic [NUM_PORTS*RID_W-1:0]       o_use_res_id,
  output logic [NUM_PORTS-1:0]             o_done,
  output logic [NUM_PORTS-1:0]             o_starve
);

  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_chan
    pool_lock_channel #(
      .ID_WIDTH    (ID_WIDTH),
      .HOLD_WIDTH  (HOLD_WIDTH),
      .RID_W       (RID_W),
      .STARVE_LIMIT(STARVE_LIMIT)
    ) u_chan (
      .clk            (clk),
      .rst_n          (rst_n),
      .i_op_valid     (i_op_valid[gi]),
      .o_op_ready     (o_op_ready[gi]),
      .i_op_issue_id  (i_op_issue_id[gi*ID_WIDTH +: ID_WIDTH]),
      .i_op_hold      (i_op_hold[gi*HOLD_WIDTH +: HOLD_WIDTH]),
      .i_flush        (i_flush),
      .o_pool_req     (o_pool_req[gi]),
      .o_pool_issue_id(o_pool_issue_id[gi*ID_WIDTH +: ID_WIDTH]),
      .o_pool_release (o_pool_release[gi]),
      .i_pool_grant   (i_pool_grant[gi]),
      .i_pool_alloc_id(i_pool_alloc_id[gi*RID_W +: RID_W]),
      .o_use_valid    (o_use_valid[gi]),
      .o_use_res_id   (o_use_res_id[gi*RID_W +: RID_W]),
      .o_done         (o_done[gi]),
      .o_starve       (o_starve[gi])
    );
  end

endmodule
